// File: rtl/cdu_drive_pkg.sv
// Shared types, register map and helpers for the CDU count injector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdu_drive_pkg;

    localparam int NUM_AXES = 5;

    // Monitor register map
    localparam logic [15:0] CDU_DRV_REG_DX     = 16'd0;
    localparam logic [15:0] CDU_DRV_REG_DY     = 16'd1;
    localparam logic [15:0] CDU_DRV_REG_DZ     = 16'd2;
    localparam logic [15:0] CDU_DRV_REG_DT     = 16'd3;
    localparam logic [15:0] CDU_DRV_REG_DS     = 16'd4;
    localparam logic [15:0] CDU_DRV_REG_RATE   = 16'd5;
    localparam logic [15:0] CDU_DRV_REG_CTRL   = 16'd6;
    localparam logic [15:0] CDU_DRV_REG_STATUS = 16'd7;

    typedef enum logic [2:0] {
        AX_IDLE,
        AX_WAIT_RATE,
        AX_WAIT_ALIGN,
        AX_ASSERT,
        AX_GAP
    } axis_state_t;

    // Two's-complement negate when neg is set. Used both to turn a signed
    // write into a magnitude and to turn sign/magnitude back into a count.
    // 16'h8000 maps onto itself, which covers the -32768 corner.
    function automatic logic [15:0] negate_if(input logic neg, input logic [15:0] v);
        return neg ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/cdu_drive_axis.sv
// One CDU axis: sign/magnitude step count, rate timer, pulse FSM.
// Latency: request rises one clk after the aligning mt1 rising edge, lasts one MCT.
// Backpressure: none; pulses are paced internally by RATE and mt1 alignment.
module cdu_drive_axis
    import cdu_drive_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        mt1_rise,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        abort,
    input  logic [15:0] rate,
    output logic        cdup,
    output logic        cdum,
    output logic        busy,
    output logic [15:0] count
);

    axis_state_t state;
    logic        sign;
    logic [15:0] rem;
    logic [15:0] timer;
    logic        fire;

    // A pulse starts only from WAIT_ALIGN with work left and enable still set
    assign fire  = (state == AX_WAIT_ALIGN) && enable && (rem != 16'd0) && mt1_rise;
    assign busy  = (rem != 16'd0) || (state != AX_IDLE);
    assign count = negate_if(sign, rem);

    // Remaining-count bookkeeping: abort beats a load, a load beats the pulse decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
            rem  <= 16'd0;
        end else if (abort) begin
            rem  <= 16'd0;
        end else if (load) begin
            sign <= load_val[15];
            rem  <= negate_if(load_val[15], load_val);
        end else if (fire) begin
            rem  <= rem - 16'd1;
        end
    end

    // Pulse FSM with registered requests; polarity is latched at pulse start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= AX_IDLE;
            timer <= 16'd0;
            cdup  <= 1'b0;
            cdum  <= 1'b0;
        end else begin
            case (state)
                AX_IDLE: begin
                    if (enable && (rem != 16'd0)) begin
                        timer <= rate;
                        state <= AX_WAIT_RATE;
                    end
                end
                AX_WAIT_RATE: begin
                    if (timer == 16'd0) begin
                        state <= AX_WAIT_ALIGN;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                AX_WAIT_ALIGN: begin
                    if (!enable || (rem == 16'd0)) begin
                        state <= AX_IDLE;
                    end else if (mt1_rise) begin
                        state <= AX_ASSERT;
                        cdup  <= ~sign;
                        cdum  <= sign;
                    end
                end
                AX_ASSERT: begin
                    if (mt1_rise) begin
                        state <= AX_GAP;
                        cdup  <= 1'b0;
                        cdum  <= 1'b0;
                    end
                end
                AX_GAP: begin
                    if (mt1_rise) begin
                        state <= AX_IDLE;
                    end
                end
                default: begin
                    state <= AX_IDLE;
                    cdup  <= 1'b0;
                    cdum  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cdu_drive.sv
// Monitor-bus front end for the five-axis CDU count injector.
// Latency: write takes effect and acks one clk after write_en; read data one clk after read_en.
// Backpressure: none; every bus access is acknowledged in a fixed single cycle.
module cdu_drive
    import cdu_drive_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_en,
    input  logic        write_en,
    output logic        write_done,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic [12:1] mt,
    output logic [4:0]  cdup,
    output logic [4:0]  cdum
);

    logic [15:0]         rate;
    logic                enable;
    logic                mt1_p;
    logic                mt1_rise;
    logic                abort;
    logic [NUM_AXES-1:0] axis_load;
    logic [NUM_AXES-1:0] axis_busy;
    logic [15:0]         axis_count [NUM_AXES];
    logic [15:0]         rd_mux;
    logic                unused_mt;

    // Only mt[1] paces the requests; the other timepulses are not needed here
    assign unused_mt = ^mt[12:2];

    assign mt1_rise = mt[1] & ~mt1_p;
    assign abort    = write_en && (addr == CDU_DRV_REG_CTRL) && data_in[1];

    // Control registers, write ack and the mt1 history bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate       <= 16'd0;
            enable     <= 1'b0;
            write_done <= 1'b0;
            mt1_p      <= 1'b0;
        end else begin
            write_done <= write_en;
            mt1_p      <= mt[1];
            if (write_en && (addr == CDU_DRV_REG_RATE)) begin
                rate <= data_in;
            end
            if (write_en && (addr == CDU_DRV_REG_CTRL)) begin
                enable <= data_in[0];
            end
        end
    end

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        assign axis_load[i] = write_en && (addr == 16'(i));

        cdu_drive_axis u_axis (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable   (enable),
            .mt1_rise (mt1_rise),
            .load     (axis_load[i]),
            .load_val (data_in),
            .abort    (abort),
            .rate     (rate),
            .cdup     (cdup[i]),
            .cdum     (cdum[i]),
            .busy     (axis_busy[i]),
            .count    (axis_count[i])
        );
    end

    // Read mux; abort bit is never stored so CTRL reads back enable only
    always_comb begin
        rd_mux = 16'd0;
        case (addr)
            CDU_DRV_REG_DX:     rd_mux = axis_count[0];
            CDU_DRV_REG_DY:     rd_mux = axis_count[1];
            CDU_DRV_REG_DZ:     rd_mux = axis_count[2];
            CDU_DRV_REG_DT:     rd_mux = axis_count[3];
            CDU_DRV_REG_DS:     rd_mux = axis_count[4];
            CDU_DRV_REG_RATE:   rd_mux = rate;
            CDU_DRV_REG_CTRL:   rd_mux = {15'd0, enable};
            CDU_DRV_REG_STATUS: rd_mux = {11'd0, axis_busy};
            default:            rd_mux = 16'd0;
        endcase
    end

    // Registered read data, held at zero outside the acknowledge cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= 16'd0;
        end else begin
            data_out <= read_en ? rd_mux : 16'd0;
        end
    end

endmodule

// File: tb/tb_cdu_drive.sv
// Self-checking bench for cdu_drive: directed corners plus randomized step counts.
// Latency: n/a.
// Backpressure: n/a.
module tb_cdu_drive;
    import cdu_drive_pkg::*;

    localparam int MCT = 24;   // clks per mt[1] period (12 timepulses x 2 clks)

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_en, write_en, write_done;
    logic [15:0] addr, data_in, data_out;
    logic [12:1] mt;
    logic [4:0]  cdup, cdum;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int phase = 0;

    // Pulse monitor state
    int  n_up [5];
    int  n_dn [5];
    int  hi_len [5];
    int  lo_len [5];
    int  last_rise [5];
    bit  have_rise [5];
    bit  up_prev [5];
    bit  dn_prev [5];
    bit  req_prev [5];
    bit  mon_hold = 1'b1;
    int  min_space = 2 * MCT;
    int  overlap = 0;

    cdu_drive dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_en    (read_en),
        .write_en   (write_en),
        .write_done (write_done),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .mt         (mt),
        .cdup       (cdup),
        .cdum       (cdum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Rotating one-hot timepulses, 2 clks each, driven away from the active edge
    always @(negedge clk) begin
        phase = (phase == 23) ? 0 : phase + 1;
        mt = 12'd1 << (phase / 2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse-shape monitor: widths, gaps, spacing and per-polarity pulse counts
    always @(negedge clk) begin
        for (int a = 0; a < 5; a++) begin
            if (mon_hold) begin
                have_rise[a] = 1'b0;
                hi_len[a]    = 0;
                lo_len[a]    = MCT;
            end else begin
                if (cdup[a] && cdum[a]) overlap++;
                if (cdup[a] && !up_prev[a]) n_up[a]++;
                if (cdum[a] && !dn_prev[a]) n_dn[a]++;
                if ((cdup[a] || cdum[a]) && !req_prev[a]) begin
                    if (have_rise[a]) begin
                        chk($sformatf("gap_ax%0d", a), 32'(lo_len[a] >= MCT), 32'd1);
                        chk($sformatf("spacing_ax%0d", a), 32'((cyc - last_rise[a]) >= min_space), 32'd1);
                    end
                    have_rise[a] = 1'b1;
                    last_rise[a] = cyc;
                    hi_len[a]    = 1;
                end else if (cdup[a] || cdum[a]) begin
                    hi_len[a]++;
                end else if (req_prev[a]) begin
                    chk($sformatf("width_ax%0d", a), 32'(hi_len[a]), 32'(MCT));
                    lo_len[a] = 1;
                end else begin
                    lo_len[a]++;
                end
            end
            up_prev[a]  = cdup[a];
            dn_prev[a]  = cdum[a];
            req_prev[a] = cdup[a] | cdum[a];
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; data_in = d; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        chk("write_done", 32'(write_done), 32'd1);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        addr = a; read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        d = data_out;
    endtask

    task automatic wait_idle(input int budget);
        logic [15:0] st;
        int k;
        k = 0;
        bus_read(CDU_DRV_REG_STATUS, st);
        while (st != 16'd0 && k < budget) begin
            bus_read(CDU_DRV_REG_STATUS, st);
            k++;
        end
        chk("status_idle", 32'(st), 32'd0);
    endtask

    task automatic wait_rises(input int a, input int target, input int budget);
        int k;
        k = 0;
        while ((n_up[a] + n_dn[a]) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("rises_ax%0d", a), 32'((n_up[a] + n_dn[a]) >= target), 32'd1);
    endtask

    task automatic clear_spacing();
        for (int a = 0; a < 5; a++) have_rise[a] = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        int su [5];
        int sd [5];

        for (int a = 0; a < 5; a++) begin
            n_up[a] = 0; n_dn[a] = 0; hi_len[a] = 0; lo_len[a] = MCT;
            last_rise[a] = 0; have_rise[a] = 0;
            up_prev[a] = 0; dn_prev[a] = 0; req_prev[a] = 0;
        end
        mt = 12'd1;
        rst_n = 1'b0; read_en = 1'b0; write_en = 1'b0; addr = 16'd0; data_in = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cdup", 32'(cdup), 32'd0);
        chk("rst_cdum", 32'(cdum), 32'd0);
        chk("rst_write_done", 32'(write_done), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_hold = 1'b0;
        for (int r = 0; r < 9; r++) begin
            bus_read(16'(r), rd);
            chk($sformatf("rst_read_%0d", r), 32'(rd), 32'd0);
        end

        // Register readback and corners, enable off
        bus_write(CDU_DRV_REG_RATE, 16'h1234);
        bus_read(CDU_DRV_REG_RATE, rd);
        chk("rate_read", 32'(rd), 32'h1234);
        bus_write(CDU_DRV_REG_CTRL, 16'h0003);
        bus_read(CDU_DRV_REG_CTRL, rd);
        chk("ctrl_read", 32'(rd), 32'h0001);
        bus_write(CDU_DRV_REG_CTRL, 16'h0000);
        bus_write(CDU_DRV_REG_DX, 16'h8000);
        bus_read(CDU_DRV_REG_DX, rd);
        chk("dx_min_read", 32'(rd), 32'h8000);
        bus_write(CDU_DRV_REG_DY, 16'hFFFE);
        bus_read(CDU_DRV_REG_DY, rd);
        chk("dy_neg_read", 32'(rd), 32'hFFFE);
        bus_read(CDU_DRV_REG_STATUS, rd);
        chk("status_loaded", 32'(rd), 32'h0003);
        bus_write(16'h0010, 16'hBEEF);
        bus_read(16'h0010, rd);
        chk("unmapped_read", 32'(rd), 32'd0);
        bus_write(CDU_DRV_REG_CTRL, 16'h0002);
        bus_read(CDU_DRV_REG_DX, rd);
        chk("abort_dx", 32'(rd), 32'd0);
        bus_read(CDU_DRV_REG_STATUS, rd);
        chk("abort_status", 32'(rd), 32'd0);

        // DX=3 at RATE=0: three plus pulses on X
        bus_write(CDU_DRV_REG_RATE, 16'd0);
        min_space = 2 * MCT;
        clear_spacing();
        su[0] = n_up[0]; sd[0] = n_dn[0];
        bus_write(CDU_DRV_REG_DX, 16'd3);
        bus_write(CDU_DRV_REG_CTRL, 16'd1);
        wait_idle(3000);
        chk("dx3_up", 32'(n_up[0] - su[0]), 32'd3);
        chk("dx3_dn", 32'(n_dn[0] - sd[0]), 32'd0);
        bus_read(CDU_DRV_REG_DX, rd);
        chk("dx3_read", 32'(rd), 32'd0);
        bus_write(CDU_DRV_REG_CTRL, 16'd0);

        // Randomized rounds against the count model
        for (int r = 0; r < 6; r++) begin
            int cnt [5];
            int rate_v;
            bit en_first;
            rate_v = int'($urandom_range(0, 60));
            bus_write(CDU_DRV_REG_RATE, 16'(rate_v));
            min_space = 2 * MCT + rate_v;
            clear_spacing();
            for (int a = 0; a < 5; a++) begin
                su[a] = n_up[a]; sd[a] = n_dn[a];
                cnt[a] = int'($urandom_range(0, 12)) - 6;
            end
            en_first = 1'($urandom_range(0, 1));
            if (en_first) bus_write(CDU_DRV_REG_CTRL, 16'd1);
            for (int a = 0; a < 5; a++) bus_write(16'(a), 16'(cnt[a]));
            if (!en_first) bus_write(CDU_DRV_REG_CTRL, 16'd1);
            wait_idle(3000);
            bus_write(CDU_DRV_REG_CTRL, 16'd0);
            for (int a = 0; a < 5; a++) begin
                chk($sformatf("rnd%0d_up_ax%0d", r, a), 32'(n_up[a] - su[a]), 32'(cnt[a] > 0 ? cnt[a] : 0));
                chk($sformatf("rnd%0d_dn_ax%0d", r, a), 32'(n_dn[a] - sd[a]), 32'(cnt[a] < 0 ? -cnt[a] : 0));
                bus_read(16'(a), rd);
                chk($sformatf("rnd%0d_read_ax%0d", r, a), 32'(rd), 32'd0);
            end
        end

        // Polarity change during pulse 4 on T
        bus_write(CDU_DRV_REG_RATE, 16'd0);
        min_space = 2 * MCT;
        clear_spacing();
        su[3] = n_up[3]; sd[3] = n_dn[3];
        bus_write(CDU_DRV_REG_DT, 16'd10);
        bus_write(CDU_DRV_REG_CTRL, 16'd1);
        wait_rises(3, su[3] + sd[3] + 4, 3000);
        bus_write(CDU_DRV_REG_DT, 16'hFFFF);
        wait_idle(3000);
        chk("dt_up", 32'(n_up[3] - su[3]), 32'd4);
        chk("dt_dn", 32'(n_dn[3] - sd[3]), 32'd1);
        bus_read(CDU_DRV_REG_DT, rd);
        chk("dt_read", 32'(rd), 32'd0);

        // Abort mid-run on Z
        su[2] = n_up[2];
        bus_write(CDU_DRV_REG_DZ, 16'd100);
        wait_rises(2, n_up[2] + n_dn[2] + 5, 3000);
        bus_write(CDU_DRV_REG_CTRL, 16'h0003);
        wait_idle(3000);
        chk("abort_upper", 32'((n_up[2] - su[2]) <= 6), 32'd1);
        chk("abort_lower", 32'((n_up[2] - su[2]) >= 5), 32'd1);
        bus_read(CDU_DRV_REG_DZ, rd);
        chk("abort_dz_read", 32'(rd), 32'd0);
        sd[2] = n_up[2];
        repeat (200) @(negedge clk);
        chk("abort_quiet", 32'(n_up[2]), 32'(sd[2]));
        bus_write(CDU_DRV_REG_CTRL, 16'd0);

        // Disabled load, enable, disable mid-run, resume
        bus_write(CDU_DRV_REG_DX, 16'd5);
        bus_write(CDU_DRV_REG_DS, 16'd5);
        bus_read(CDU_DRV_REG_STATUS, rd);
        chk("dis_status", 32'(rd), 32'h0011);
        su[0] = n_up[0]; su[4] = n_up[4];
        repeat (100) @(negedge clk);
        chk("dis_quiet_x", 32'(n_up[0] - su[0]), 32'd0);
        chk("dis_quiet_s", 32'(n_up[4] - su[4]), 32'd0);
        bus_write(CDU_DRV_REG_CTRL, 16'd1);
        wait_rises(0, n_up[0] + n_dn[0] + 2, 3000);
        bus_write(CDU_DRV_REG_CTRL, 16'd0);
        repeat (150) @(negedge clk);
        bus_read(CDU_DRV_REG_DX, rd);
        chk("dis_x_sum", 32'(int'(rd) + n_up[0] - su[0]), 32'd5);
        bus_read(CDU_DRV_REG_DS, rd);
        chk("dis_s_sum", 32'(int'(rd) + n_up[4] - su[4]), 32'd5);
        sd[0] = n_up[0];
        repeat (100) @(negedge clk);
        chk("dis_held", 32'(n_up[0]), 32'(sd[0]));
        bus_write(CDU_DRV_REG_CTRL, 16'd1);
        wait_idle(3000);
        chk("resume_x", 32'(n_up[0] - su[0]), 32'd5);
        chk("resume_s", 32'(n_up[4] - su[4]), 32'd5);

        // Asynchronous reset during a pulse
        bus_write(CDU_DRV_REG_DX, 16'd3);
        wait_rises(0, n_up[0] + n_dn[0] + 1, 3000);
        mon_hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cdup", 32'(cdup), 32'd0);
        chk("arst_cdum", 32'(cdum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < 8; r++) begin
            bus_read(16'(r), rd);
            chk($sformatf("post_rst_read_%0d", r), 32'(rd), 32'd0);
        end
        mon_hold = 1'b0;

        chk("overlap", 32'(overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
